// File: rtl/datapath_pkg.sv
// Shared definitions for the accumulator machine: widths, opcodes and the A-input mux encoding.
// Used by both the control unit and the datapath.
package datapath_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 5;
   localparam int MEM_DEPTH = 32;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_STORE = 3'b001,
      OP_ADD   = 3'b010,
      OP_SUB   = 3'b011,
      OP_INPUT = 3'b100,
      OP_JZ    = 3'b101,
      OP_JPOS  = 3'b110,
      OP_HALT  = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ASEL_ALU   = 2'b00,
      ASEL_INPUT = 2'b01,
      ASEL_MEM   = 2'b10,
      ASEL_ZERO  = 2'b11
   } asel_e;

   // Modulo-256 add/subtract; carry and overflow are intentionally dropped.
   function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              sub);
      return sub ? (a - b) : (a + b);
   endfunction

endpackage

// File: rtl/datapath_ram32x8.sv
// 32x8 program/data memory: asynchronous read, synchronous write.
// Port A (program preload) has priority over port B (store from accumulator).
module ram32x8
   import datapath_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_we_a,
   input  logic [ADDR_W-1:0] i_addr_a,
   input  logic [DATA_W-1:0] i_data_a,
   input  logic              i_we_b,
   input  logic [ADDR_W-1:0] i_addr_b,
   input  logic [DATA_W-1:0] i_data_b,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   // No reset on the array so preloaded programs survive a reset.
   always_ff @(posedge i_clk) begin
      if (i_we_a) begin
         r_mem[i_addr_a] <= i_data_a;
      end else if (i_we_b) begin
         r_mem[i_addr_b] <= i_data_b;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/datapath.sv
// Accumulator-machine datapath: IR, PC, accumulator, ALU, A-input mux and program memory.
// All sequencing decisions come from the external control unit.
module datapath
   import datapath_pkg::*;
(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              IRload,
   input  logic              PCload,
   input  logic              JMPmux,
   input  logic              Meminst,
   input  logic              MemWr,
   input  logic              Aload,
   input  logic              Sub,
   input  logic [1:0]        Asel,
   input  logic              Halt,
   input  logic [DATA_W-1:0] Input,
   input  logic              LoadEn,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [DATA_W-1:0] LoadData,
   output logic [2:0]        IR,
   output logic              Aeq0,
   output logic              Apos,
   output logic [DATA_W-1:0] Output,
   output logic [ADDR_W-1:0] PC,
   output logic              Halted
);

   logic [DATA_W-1:0] r_ir;
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_a;
   logic              r_halted;

   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_mem_data;
   logic [DATA_W-1:0] w_alu;
   logic [DATA_W-1:0] w_amux;
   logic              w_mem_we;

   assign w_addr   = Meminst ? r_ir[ADDR_W-1:0] : r_pc;
   assign w_alu    = alu_f(r_a, w_mem_data, Sub);
   assign w_mem_we = MemWr & ~Halt;

   always_comb begin
      w_amux = '0;
      case (asel_e'(Asel))
         ASEL_ALU:   w_amux = w_alu;
         ASEL_INPUT: w_amux = Input;
         ASEL_MEM:   w_amux = w_mem_data;
         ASEL_ZERO:  w_amux = '0;
         default:    w_amux = '0;
      endcase
   end

   ram32x8 u_ram (
      .i_clk    (Clock),
      .i_we_a   (LoadEn),
      .i_addr_a (LoadAddr),
      .i_data_a (LoadData),
      .i_we_b   (w_mem_we),
      .i_addr_b (w_addr),
      .i_data_b (r_a),
      .i_raddr  (w_addr),
      .o_rdata  (w_mem_data)
   );

   // Halt freezes architectural state; Halted is sticky until reset.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_ir     <= '0;
         r_pc     <= '0;
         r_a      <= '0;
         r_halted <= 1'b0;
      end else if (Halt) begin
         r_halted <= 1'b1;
      end else begin
         if (IRload) r_ir <= w_mem_data;
         if (PCload) r_pc <= JMPmux ? r_ir[ADDR_W-1:0] : (r_pc + 5'd1);
         if (Aload)  r_a  <= w_amux;
      end
   end

   assign IR     = r_ir[DATA_W-1:DATA_W-3];
   assign Aeq0   = (r_a == '0);
   assign Apos   = ~r_a[DATA_W-1] & (r_a != '0);
   assign Output = r_a;
   assign PC     = r_pc;
   assign Halted = r_halted;

endmodule

// File: tb/tb_datapath.sv
// Directed, table-driven bench for the datapath with hand-computed expected values.
module tb_datapath;

   logic       Clock, Reset;
   logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
   logic [1:0] Asel;
   logic [7:0] Input;
   logic       LoadEn;
   logic [4:0] LoadAddr;
   logic [7:0] LoadData;
   logic [2:0] IR;
   logic       Aeq0, Apos, Halted;
   logic [7:0] Output;
   logic [4:0] PC;

   int n_cmp = 0;
   int n_err = 0;

   datapath dut (
      .Clock(Clock), .Reset(Reset), .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux),
      .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel),
      .Halt(Halt), .Input(Input), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
      .LoadData(LoadData), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Output(Output),
      .PC(PC), .Halted(Halted)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ctrl = {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub}
   typedef struct {
      logic [6:0] ctrl;
      logic [1:0] asel;
      logic [7:0] inp;
      logic [2:0] e_ir;
      logic [4:0] e_pc;
      logic [7:0] e_a;
      logic       e_aeq0;
      logic       e_apos;
   } vec_t;

   function automatic vec_t mk(input logic [6:0] ctrl, input logic [1:0] asel,
                               input logic [7:0] inp, input logic [2:0] e_ir,
                               input logic [4:0] e_pc, input logic [7:0] e_a,
                               input logic e_aeq0, input logic e_apos);
      vec_t v;
      v.ctrl = ctrl; v.asel = asel; v.inp = inp;
      v.e_ir = e_ir; v.e_pc = e_pc; v.e_a = e_a;
      v.e_aeq0 = e_aeq0; v.e_apos = e_apos;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input vec_t v);
      chk({tag, ".ir"},   {5'd0, IR},   {5'd0, v.e_ir});
      chk({tag, ".pc"},   {3'd0, PC},   {3'd0, v.e_pc});
      chk({tag, ".a"},    Output,       v.e_a);
      chk({tag, ".aeq0"}, {7'd0, Aeq0}, {7'd0, v.e_aeq0});
      chk({tag, ".apos"}, {7'd0, Apos}, {7'd0, v.e_apos});
   endtask

   task automatic clr();
      {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub} = 7'b0;
      Asel = 2'b00; Input = 8'h00; Halt = 1'b0;
      LoadEn = 1'b0; LoadAddr = 5'd0; LoadData = 8'h00;
   endtask

   task automatic run(input string tag, input vec_t v);
      {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub} = v.ctrl;
      Asel  = v.asel;
      Input = v.inp;
      @(posedge Clock);
      #1;
      chk_outs(tag, v);
   endtask

   task automatic preload(input logic [4:0] addr, input logic [7:0] data);
      {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub} = 7'b0;
      LoadEn = 1'b1; LoadAddr = addr; LoadData = data;
      @(posedge Clock);
      #1;
      LoadEn = 1'b0;
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = mk(7'b1100000, 2'b00, 8'h00, 3'b000, 5'd1, 8'h00, 1'b1, 1'b0); // fetch LOAD 5
      tbl[1]  = mk(7'b0001010, 2'b10, 8'h00, 3'b000, 5'd1, 8'h7F, 1'b0, 1'b1); // A=mem[5]
      tbl[2]  = mk(7'b0000010, 2'b01, 8'h01, 3'b000, 5'd1, 8'h01, 1'b0, 1'b1); // A=Input
      tbl[3]  = mk(7'b1100000, 2'b00, 8'h00, 3'b010, 5'd2, 8'h01, 1'b0, 1'b1); // fetch 8'h43
      tbl[4]  = mk(7'b0001011, 2'b00, 8'h00, 3'b010, 5'd2, 8'hFF, 1'b0, 1'b0); // 1-2
      tbl[5]  = mk(7'b1100000, 2'b00, 8'h00, 3'b100, 5'd3, 8'hFF, 1'b0, 1'b0); // fetch 8'h84
      tbl[6]  = mk(7'b0001010, 2'b00, 8'h00, 3'b100, 5'd3, 8'h00, 1'b1, 1'b0); // FF+1
      tbl[7]  = mk(7'b1100010, 2'b10, 8'h00, 3'b000, 5'd4, 8'h02, 1'b0, 1'b1); // simultaneous
      tbl[8]  = mk(7'b0001100, 2'b00, 8'h00, 3'b000, 5'd4, 8'h02, 1'b0, 1'b1); // mem[2]=A
      tbl[9]  = mk(7'b0000010, 2'b11, 8'h00, 3'b000, 5'd4, 8'h00, 1'b1, 1'b0); // A=0
      tbl[10] = mk(7'b0001010, 2'b10, 8'h00, 3'b000, 5'd4, 8'h02, 1'b0, 1'b1); // read back mem[2]
      tbl[11] = mk(7'b0000010, 2'b01, 8'h80, 3'b000, 5'd4, 8'h80, 1'b0, 1'b0); // negative

      clr();
      Reset = 1'b0;
      #1;
      chk_outs("rst0", mk(7'b0, 2'b0, 8'h0, 3'b000, 5'd0, 8'h00, 1'b1, 1'b0));
      chk("rst0.halted", {7'd0, Halted}, 8'h00);

      // Program preload while reset is held.
      preload(5'd0, 8'h05);
      preload(5'd1, 8'h43);
      preload(5'd2, 8'h84);
      preload(5'd3, 8'h02);
      preload(5'd4, 8'h01);
      preload(5'd5, 8'h7F);
      Reset = 1'b1;

      for (int i = 0; i < 12; i++) run($sformatf("v%0d", i), tbl[i]);

      // PC wrap and jump through IR
      preload(5'd4, 8'hBF);
      run("wrap.ir",   mk(7'b1000000, 2'b00, 8'h00, 3'b101, 5'd4,  8'h80, 1'b0, 1'b0));
      run("wrap.jmp",  mk(7'b0110000, 2'b00, 8'h00, 3'b101, 5'd31, 8'h80, 1'b0, 1'b0));
      run("wrap.inc",  mk(7'b0100000, 2'b00, 8'h00, 3'b101, 5'd0,  8'h80, 1'b0, 1'b0));
      preload(5'd0, 8'hB4);
      run("jz.ir",     mk(7'b1000000, 2'b00, 8'h00, 3'b101, 5'd0,  8'h80, 1'b0, 1'b0));
      run("jz.zero",   mk(7'b0000010, 2'b11, 8'h00, 3'b101, 5'd0,  8'h00, 1'b1, 1'b0));
      run("jz.jmp",    mk(7'b0110000, 2'b00, 8'h00, 3'b101, 5'd20, 8'h00, 1'b1, 1'b0));

      // LoadEn wins over MemWr on the same address
      preload(5'd20, 8'h09);
      run("col.ir",    mk(7'b1000000, 2'b00, 8'h00, 3'b000, 5'd20, 8'h00, 1'b1, 1'b0));
      run("col.a",     mk(7'b0000010, 2'b01, 8'h33, 3'b000, 5'd20, 8'h33, 1'b0, 1'b1));
      LoadEn = 1'b1; LoadAddr = 5'd9; LoadData = 8'hAA;
      run("col.wr",    mk(7'b0001100, 2'b00, 8'h00, 3'b000, 5'd20, 8'h33, 1'b0, 1'b1));
      LoadEn = 1'b0;
      run("col.rd",    mk(7'b0001010, 2'b10, 8'h00, 3'b000, 5'd20, 8'hAA, 1'b0, 1'b0));

      // Mid-operation async reset with A=5A, PC=7
      preload(5'd20, 8'h07);
      run("pre.ir",    mk(7'b1000000, 2'b00, 8'h00, 3'b000, 5'd20, 8'hAA, 1'b0, 1'b0));
      run("pre.jmp",   mk(7'b0110000, 2'b00, 8'h00, 3'b000, 5'd7,  8'hAA, 1'b0, 1'b0));
      run("pre.a",     mk(7'b0000010, 2'b01, 8'h5A, 3'b000, 5'd7,  8'h5A, 1'b0, 1'b1));
      {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub} = 7'b1100010;
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      chk_outs("arst", mk(7'b0, 2'b0, 8'h0, 3'b000, 5'd0, 8'h00, 1'b1, 1'b0));
      preload(5'd0, 8'h09);
      Reset = 1'b1;
      run("post.m0",   mk(7'b0000010, 2'b10, 8'h00, 3'b000, 5'd0, 8'h09, 1'b0, 1'b1));
      run("post.ir",   mk(7'b1000000, 2'b00, 8'h00, 3'b000, 5'd0, 8'h09, 1'b0, 1'b1));
      run("post.m9",   mk(7'b0001010, 2'b10, 8'h00, 3'b000, 5'd0, 8'hAA, 1'b0, 1'b0));

      // Halt freezes state and blocks MemWr; LoadEn still writes
      Halt = 1'b1; LoadEn = 1'b1; LoadAddr = 5'd9; LoadData = 8'h77;
      run("halt",      mk(7'b1100110, 2'b01, 8'h44, 3'b000, 5'd0, 8'hAA, 1'b0, 1'b0));
      chk("halt.halted", {7'd0, Halted}, 8'h01);
      Halt = 1'b0; LoadEn = 1'b0;
      run("halt.idle", mk(7'b0000000, 2'b00, 8'h00, 3'b000, 5'd0, 8'hAA, 1'b0, 1'b0));
      chk("halt.sticky", {7'd0, Halted}, 8'h01);
      run("halt.m0",   mk(7'b0000010, 2'b10, 8'h00, 3'b000, 5'd0, 8'h09, 1'b0, 1'b1));
      run("halt.m9",   mk(7'b0001010, 2'b10, 8'h00, 3'b000, 5'd0, 8'h77, 1'b0, 1'b1));
      chk("halt.sticky2", {7'd0, Halted}, 8'h01);
      clr();
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      chk("rst.halted", {7'd0, Halted}, 8'h00);
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all registers update on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have control inputs IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub (1 each) and Asel (2), all driven by the control unit.
REQ-004 SHALL have port Halt, input, 1, from control unit; when 1 the datapath freezes all state.
REQ-005 SHALL have port Input, input, 8, user data word.
REQ-006 SHALL have ports LoadEn (1), LoadAddr (5), LoadData (8), inputs, program-preload write port.
REQ-007 SHALL have port IR, output, 3, opcode field IR_reg[7:5] returned to the control unit.
REQ-008 SHALL have ports Aeq0 and Apos, outputs, 1 each, accumulator status flags.
REQ-009 SHALL have port Output, output, 8, current accumulator value.
REQ-010 SHALL have ports PC, output, 5, and Halted, output, 1, debug/status.

Function
REQ-011 SHALL contain an 8-bit IR_reg, a 5-bit PC register, an 8-bit accumulator A and a 32x8 memory.
REQ-012 SHALL form the memory address as IR_reg[4:0] when Meminst=1, else PC.
REQ-013 SHALL read memory combinationally (same-cycle data at the selected address).
REQ-014 SHALL load IR_reg with mem[address] on a rising edge when IRload=1.
REQ-015 SHALL load PC with IR_reg[4:0] when PCload=1 and JMPmux=1, or with PC+1 when PCload=1 and JMPmux=0.
REQ-016 SHALL wrap PC from 31 to 0 on increment.
REQ-017 SHALL compute ALU result = A + mem_data when Sub=0, A - mem_data when Sub=1, 8-bit two's complement, modulo 256, no carry/overflow output.
REQ-018 SHALL select the A-input mux: Asel=00 ALU result, 01 Input, 10 mem_data, 11 8'h00.
REQ-019 SHALL load A with the mux output on a rising edge when Aload=1.
REQ-020 SHALL write A into mem[address] on a rising edge when MemWr=1.
REQ-021 SHALL give LoadEn priority: when LoadEn=1, write LoadData to mem[LoadAddr] and ignore MemWr that cycle.
REQ-022 SHALL accept LoadEn writes whether Reset is asserted or not.
REQ-023 SHALL drive Aeq0=1 exactly when A==0, combinationally.
REQ-024 SHALL drive Apos=1 exactly when A[7]==0 and A!=0, combinationally.
REQ-025 SHALL, when Halt=1, block IR_reg, PC, A and MemWr updates; LoadEn writes remain allowed.
REQ-026 SHALL set Halted=1 on the first rising edge with Halt=1 and hold it until reset.
REQ-027 SHALL apply simultaneous IRload, PCload and Aload updates on the same edge, all using pre-edge values.

Reset
REQ-028 SHALL, while Reset=0, force IR_reg=0, PC=0, A=0, Halted=0 asynchronously; hence Output=0, IR=000, Aeq0=1, Apos=0.
REQ-029 SHALL leave memory contents unaffected by Reset.
REQ-030 SHALL discard any in-progress instruction when Reset is asserted mid-operation; execution restarts at PC=0.

Structure
REQ-031 SHALL place the opcode constants (LOAD=000 ... HALT=111), Asel encodings and widths (DATA_W=8, ADDR_W=5, MEM_DEPTH=32) in a shared package used by both control unit and datapath.
REQ-032 SHALL implement the memory as one sub-module, ram32x8 (asynchronous read, synchronous write, two write ports muxed by LoadEn).

Verification
REQ-033 Reset asserted with A=8'h5A, PC=7 -> immediately A=0, PC=0, Aeq0=1, Apos=0; preloaded memory unchanged.
REQ-034 Preload mem[0]=8'h05 (LOAD 5), mem[5]=8'h7F; fetch (IRload,PCload) then load (Asel=10, Aload) -> IR=000, PC=1, A=8'h7F, Apos=1.
REQ-035 A=8'h01, mem[3]=8'h02, Meminst=1, IR_reg[4:0]=3, Sub=1, Aload -> A=8'hFF, Apos=0, Aeq0=0; then Sub=0 add with mem=8'h01 -> A=8'h00, Aeq0=1.
REQ-036 PC=31, PCload=1, JMPmux=0 -> PC=0; IR_reg=8'hB4 (JZ 20), A=0, PCload=1, JMPmux=1 -> PC=20.
REQ-037 A=8'h33, MemWr=1, Meminst=1, IR_reg[4:0]=9 with LoadEn=1, LoadAddr=9, LoadData=8'hAA same edge -> mem[9]=8'hAA.
REQ-038 Halt=1 with Aload=1, Input=8'h44 -> A unchanged, Halted=1 until Reset; LoadEn write still updates memory.
